div_seq_ctrl: RTL and testbench

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 24 ++
 rtl/div_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_div_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: state encoding and sizing constants.
package div_pkg;

  localparam int unsigned DivWidth  = 32;
  // One restoring step per quotient bit.
  localparam int unsigned IterCount = DivWidth;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift {rem,quo} left, trial-subtract the divisor magnitude.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH:0]   div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           fits;

  // rem < |divisor| <= 2^(WIDTH-1), so rem_sh < 2^WIDTH and diff[WIDTH] is a valid sign.
  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  assign diff   = rem_sh - div_i;
  assign fits   = ~diff[WIDTH];

  assign rem_o = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential signed (truncating) divider: one restoring step per cycle, sign fix-up, done pulse.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned    CntW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  div_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   div_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH:0]   divisor_ext;
  logic [WIDTH:0]   divisor_mag;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits WIDTH bits when read as unsigned.
  assign dividend_mag = dividend[WIDTH-1] ? (WIDTH'(0) - dividend) : dividend;
  assign divisor_ext  = {divisor[WIDTH-1], divisor};
  assign divisor_mag  = divisor[WIDTH-1] ? ((WIDTH+1)'(0) - divisor_ext) : divisor_ext;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            busy_q <= 1'b1;
            if (divisor == '0) begin
              quotient_q  <= '0;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end else begin
              quo_q     <= dividend_mag;
              rem_q     <= '0;
              div_q     <= divisor_mag;
              neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_rem_q <= dividend[WIDTH-1];
              cnt_q     <= '0;
              state_q   <= StIter;
            end
          end
        end
        StIter: begin
          quo_q <= step_quo;
          rem_q <= step_rem;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastIter) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          quotient_q  <= neg_quo_q ? (WIDTH'(0) - quo_q) : quo_q;
          remainder_q <= neg_rem_q ? (WIDTH'(0) - rem_q) : rem_q;
          dbz_q       <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: vector table, random ops vs. a model, abort/ignore sequences.
module tb_div_seq_ctrl;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  div_seq_ctrl #(
    .WIDTH (32)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   m;
    longint sa, sb_l, q, r;
    if (b == 32'd0) begin
      m.q = 32'd0;
      m.r = a;
      m.z = 1'b1;
    end else begin
      sa   = longint'($signed(a));
      sb_l = longint'($signed(b));
      q    = sa / sb_l;
      r    = sa % sb_l;
      m.q  = q[31:0];
      m.r  = r[31:0];
      m.z  = 1'b0;
    end
    return m;
  endfunction

  // Counts edges since start was sampled (edge 1) until done is seen, bounded.
  task automatic wait_done(input int from, output int edges);
    edges = from;
    while (done !== 1'b1 && edges < 60) begin
      @(negedge clock);
      edges++;
    end
  endtask

  task automatic check_result();
    exp_t e;
    if (sb.size() == 0) begin
      total_cnt++;
      $display("FAIL scoreboard: done seen with no expected entry, got 0 entries, expected 1");
    end else begin
      e = sb.pop_front();
      check("quotient", quotient, e.q);
      check("remainder", remainder, e.r);
      check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input exp_t e, input int lat);
    int edges;
    sb.push_back(e);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(1, edges);
    check("latency", 32'(edges), 32'(lat));
    check_result();
    @(negedge clock);
    check("done_single_pulse", {31'd0, done}, 32'd0);
    check("busy_back_idle", {31'd0, busy}, 32'd0);
    check("quotient_hold", quotient, e.q);
  endtask

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   edges;
    int   n;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd100,        32'd7,          '{32'd14,         32'd2,          1'b0}, 34};
    vecs[1] = '{32'hFFFFFF9C,   32'd7,          '{32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0}, 34};
    vecs[2] = '{32'd100,        32'hFFFFFFF9,   '{32'hFFFFFFF2,   32'd2,          1'b0}, 34};
    vecs[3] = '{32'd7,          32'd0,          '{32'd0,          32'd7,          1'b1}, 1};
    vecs[4] = '{32'd9,          32'd3,          '{32'd3,          32'd0,          1'b0}, 34};
    vecs[5] = '{32'h80000000,   32'hFFFFFFFF,   '{32'h80000000,   32'd0,          1'b0}, 34};
    vecs[6] = '{32'h80000000,   32'd1,          '{32'h80000000,   32'd0,          1'b0}, 34};
    vecs[7] = '{32'h7FFFFFFF,   32'h80000000,   '{32'd0,          32'h7FFFFFFF,   1'b0}, 34};
    vecs[8] = '{32'hFFFFFFFF,   32'd0,          '{32'd0,          32'hFFFFFFFF,   1'b1}, 1};
    vecs[9] = '{32'd3,          32'd5,          '{32'd0,          32'd3,          1'b0}, 34};

    clear    = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (2) @(negedge clock);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    clear = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].lat);
    end

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(ra, rb, model(ra, rb), (rb == 32'd0) ? 1 : 34);
    end

    // Start pulse with new operands mid-operation must be ignored.
    sb.push_back('{32'd14, 32'd2, 1'b0});
    @(negedge clock);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    start    = 1'b1;
    dividend = 32'd5;
    divisor  = 32'd1;
    @(negedge clock);
    start    = 1'b0;
    dividend = 32'd9;
    divisor  = 32'd3;
    wait_done(10, edges);
    check("ignore_latency", 32'(edges), 32'd34);
    check_result();
    n = 0;
    repeat (10) begin
      @(negedge clock);
      if (done) n++;
    end
    check("ignore_no_extra_done", 32'(n), 32'd0);

    // Clear mid-operation aborts with no done, outputs zeroed at once.
    @(negedge clock);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (13) @(negedge clock);
    #2 clear = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clock);
    clear = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) n++;
    end
    check("abort_no_done", 32'(n), 32'd0);
    run_op(32'd50, 32'd5, '{32'd10, 32'd0, 1'b0}, 34);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
